// File: rtl/stopwatch_pkg.sv
// Shared types and seven-segment glyph constants for the stopwatch display path.
// Glyph bit order is {g,f,e,d,c,b,a}, active-low.
package stopwatch_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  // One displayed time value, as four digits.
  typedef struct packed {
    logic [2:0] min_t;
    bcd_t       min_u;
    logic [2:0] sec_t;
    bcd_t       sec_u;
  } time_digits_t;

  localparam seg_t SEG_0    = 7'b1000000;
  localparam seg_t SEG_1    = 7'b1111001;
  localparam seg_t SEG_2    = 7'b0100100;
  localparam seg_t SEG_3    = 7'b0110000;
  localparam seg_t SEG_4    = 7'b0011001;
  localparam seg_t SEG_5    = 7'b0010010;
  localparam seg_t SEG_6    = 7'b0000010;
  localparam seg_t SEG_7    = 7'b1111000;
  localparam seg_t SEG_8    = 7'b0000000;
  localparam seg_t SEG_9    = 7'b0010000;
  localparam seg_t SEG_DASH = 7'b0111111;
  localparam seg_t SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam bcd_t       BCD_BAD = 4'hF;

  // Widen a tens digit for the BCD decoder, forcing anything above 5 to a code it shows as a dash.
  function automatic bcd_t tens_to_bcd(input logic [2:0] tens);
    return (tens > 3'd5) ? BCD_BAD : {1'b0, tens};
  endfunction

  function automatic logic [3:0] one_cold(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment glyph decoder; codes above 9 give the dash glyph.
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  bcd_t digit_i,
  output seg_t seg_o
);

  // NOTE: the default arm assigns seg_o on every path, so no latch can be inferred.
  always_comb begin
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Four-digit multiplexed display scanner with lap freeze and a blank slot between digits.
// Optional LEADING_ZERO_BLANK_EN blanks the minutes-tens digit when it shows 0.
module digit_scan_mux
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sec_u,
  input  logic [2:0] sec_t,
  input  logic [3:0] min_u,
  input  logic [2:0] min_t,
  input  logic       lap,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  digit_idx_t    idx_q, idx_d;
  logic          lap_q;
  time_digits_t  hold_q, hold_d;
  logic [3:0]    an_q, an_d;
  seg_t          seg_q, seg_d;
  logic          dp_q, dp_d;

  time_digits_t live, src;
  bcd_t         mux_digit;
  seg_t         glyph;
  logic         slot_end;

  assign live     = {min_t, min_u, sec_t, sec_u};
  assign src      = lap_q ? hold_q : live;
  assign slot_end = (div_cnt_q == DIV_LAST);

  always_comb begin
    case (idx_q)
      2'd0:    mux_digit = src.sec_u;
      2'd1:    mux_digit = tens_to_bcd(src.sec_t);
      2'd2:    mux_digit = src.min_u;
      default: mux_digit = tens_to_bcd(src.min_t);
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .digit_i (mux_digit),
    .seg_o   (glyph)
  );

  always_comb begin
    div_cnt_d = slot_end ? '0 : div_cnt_q + CW'(1);
    idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
    hold_d    = (lap && !lap_q) ? live : hold_q;

    // The last cycle of every slot is blanked so the old glyph never ghosts onto the next digit.
    if (slot_end) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else begin
      an_d  = one_cold(idx_q);
      seg_d = glyph;
      dp_d  = (idx_q != 2'd2);
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_q == 2'd3 && src.min_t == 3'd0) begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
      end
`endif
    end
  end

  // NOTE: every register below uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      lap_q     <= 1'b0;
      hold_q    <= '0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      lap_q     <= lap;
      hold_q    <= hold_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Randomized self-checking bench for digit_scan_mux (SCAN_DIV=4) against a slot-arithmetic reference model.
module tb_digit_scan_mux;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sec_u = '0;
  logic [2:0] sec_t = '0;
  logic [3:0] min_u = '0;
  logic [2:0] min_t = '0;
  logic       lap = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;

  // Reference model state: edges since reset release, previous lap level, captured digits.
  int    k = 0;
  bit    lap_prev = 1'b0;
  int    hold [4] = '{0, 0, 0, 0};
  string phase = "init";

  logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  digit_scan_mux #(.SCAN_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .sec_u (sec_u),
    .sec_t (sec_t),
    .min_u (min_u),
    .min_t (min_t),
    .lap   (lap),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {an,seg,dp} after edge number kk, given the digits selected as display source.
  function automatic logic [11:0] expect_out(input int kk, input int d [4]);
    int         pos;
    int         slot;
    int         v;
    int         lim;
    logic [3:0] a;
    logic [6:0] s;
    logic       p;
    pos  = kk % DIV;
    slot = (kk / DIV) % 4;
    if (pos == DIV - 1) return 12'hFFF;
    v   = d[slot];
    lim = (slot == 1 || slot == 3) ? 5 : 9;
    s   = (v > lim) ? 7'b0111111 : glyph[v];
    a   = 4'b1111;
    a[slot] = 1'b0;
    p   = (slot == 2) ? 1'b0 : 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 3 && v == 0) begin
      a = 4'b1111;
      s = 7'b1111111;
    end
`endif
    return {a, s, p};
  endfunction

  task automatic cycle(input int su, input int st, input int mu, input int mt, input bit l);
    int          live [4];
    int          src [4];
    logic [11:0] e;
    @(negedge clk);
    sec_u = su[3:0];
    sec_t = st[2:0];
    min_u = mu[3:0];
    min_t = mt[2:0];
    lap   = l;
    live  = '{su, st, mu, mt};
    @(posedge clk);
    if (lap_prev) src = hold;
    else          src = live;
    e = expect_out(k, src);
    if (l && !lap_prev) hold = live;
    lap_prev = l;
    #1;
    check($sformatf("%s k=%0d", phase, k), {an, seg, dp}, e);
    k++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", {an, seg, dp}, 12'hFFF);
    @(posedge clk);
    #1;
    check("reset_held", {an, seg, dp}, 12'hFFF);
    reset    = 1'b0;
    k        = 0;
    lap_prev = 1'b0;
    hold     = '{0, 0, 0, 0};
  endtask

  initial begin
    int r_su, r_st, r_mu, r_mt;
    bit r_lap;

    phase = "reset0";
    do_reset();
    cycle(7, 3, 9, 5, 0);
    check("first_an", an, 4'b1110);

    phase = "scan";
    for (int i = 0; i < 2 * 4 * DIV; i++) cycle(7, 3, 9, 5, 0);

    phase = "reset_mid_scan";
    do_reset();
    cycle(7, 3, 9, 5, 0);
    check("first_an_2", an, 4'b1110);

    phase = "lap_freeze";
    cycle(7, 3, 9, 5, 1);
    for (int i = 0; i < 20; i++) cycle(8, 3, 9, 5, 1);
    phase = "lap_release";
    for (int i = 0; i < 20; i++) cycle(8, 3, 9, 5, 0);

    phase = "lap_same_edge";
    cycle(3, 1, 2, 4, 1);
    for (int i = 0; i < 16; i++) cycle(4, 2, 6, 1, 1);
    cycle(4, 2, 6, 1, 0);

    phase = "lap_pulse";
    for (int i = 0; i < 6; i++) begin
      cycle(5, 0, 1, 2, 1);
      cycle(6, 4, 3, 0, 0);
      cycle(i, 5, 7, 3, 0);
    end

    phase = "dash";
    for (int i = 0; i < 16; i++) cycle(12, 6, 15, 7, 0);

    phase = "min_t_zero";
    for (int i = 0; i < 16; i++) cycle(1, 2, 3, 0, 0);

    phase = "reset_mid_freeze";
    cycle(9, 5, 9, 5, 1);
    cycle(0, 0, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 16; i++) cycle(2, 4, 8, 3, 1);
    cycle(2, 4, 8, 3, 0);

    phase = "random";
    r_su = 0; r_st = 0; r_mu = 0; r_mt = 0; r_lap = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        r_su = $urandom_range(0, 15);
        r_st = $urandom_range(0, 7);
        r_mu = $urandom_range(0, 15);
        r_mt = $urandom_range(0, 7);
      end
      if ($urandom_range(0, 6) == 0) r_lap = !r_lap;
      cycle(r_su, r_st, r_mu, r_mt, r_lap);
      if (i == 300) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_scan_mux.md
DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 Parameter: SCAN_DIV, default 50000, clk cycles per digit slot; legal range >= 2.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sec_u  input  4  seconds-units BCD digit, 0-9.
REQ-005 sec_t  input  3  seconds-tens digit, 0-5.
REQ-006 min_u  input  4  minutes-units BCD digit, 0-9.
REQ-007 min_t  input  3  minutes-tens digit, 0-5.
REQ-008 lap  input  1  level; high freezes the displayed time.
REQ-009 an  output  4  digit enables, active-low; bit0 = sec_u, bit1 = sec_t, bit2 = min_u, bit3 = min_t.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.

Function
REQ-012 div_cnt SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-013 At the edge where div_cnt==SCAN_DIV-1, idx (2-bit) SHALL advance 0->1->2->3->0.
REQ-014 an, seg and dp SHALL be registered outputs.
REQ-015 At the edge where div_cnt==SCAN_DIV-1 the outputs SHALL load the blank value an=1111, seg=1111111, dp=1 (anti-ghost blank cycle).
REQ-016 At every other edge an SHALL load the one-cold decode of idx, and seg SHALL load the glyph of the digit selected by idx.
REQ-017 Each digit SHALL therefore be lit SCAN_DIV-1 cycles out of every SCAN_DIV, scan order sec_u, sec_t, min_u, min_t.
REQ-018 Glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 Any digit value above its legal range (BCD >9, tens >5) SHALL display the dash glyph 0111111.
REQ-020 dp SHALL be 0 while idx==2 and the cycle is not blank; otherwise dp SHALL be 1.
REQ-021 lap_d SHALL register lap every cycle.
REQ-022 On lap & ~lap_d, all four inputs SHALL be captured into the hold registers.
REQ-023 While lap_d==1 the displayed source SHALL be the hold registers; otherwise it SHALL be the live inputs.
REQ-024 A lap pulse of one cycle SHALL still capture, and SHALL freeze the display for exactly that one cycle of source selection.
REQ-025 Live input changes while frozen SHALL NOT affect seg; after lap falls, the next non-blank cycle SHALL show the live value.

Reset
REQ-026 reset SHALL immediately force div_cnt=0, idx=0, lap_d=0, hold registers=0, an=1111, seg=1111111 and dp=1.
REQ-027 Reset asserted mid-scan or mid-freeze SHALL discard all scan and hold state.
REQ-028 After reset release, the first edge SHALL light sec_u (an=1110).

Configuration
REQ-029 Macro LEADING_ZERO_BLANK_EN: when defined, a min_t slot whose displayed value is 0 SHALL output an=1111 and seg=1111111; scan timing is unchanged.
REQ-030 When LEADING_ZERO_BLANK_EN is undefined, min_t=0 SHALL display glyph 0 with an=0111.

Structure
REQ-031 Package stopwatch_pkg SHALL hold the glyph constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF), a 2-bit digit-index typedef and the BCD digit typedef.
REQ-032 A combinational sub-module bcd_to_seg (4-bit digit in, 7-bit glyph out, dash for >9) SHALL be instantiated once on the muxed digit.
REQ-033 Range checking of the tens digits (>5 -> dash) SHALL be done in digit_scan_mux before the decoder.

Verification (SCAN_DIV=4)
REQ-034 Reset asserted at an arbitrary cycle -> an=1111, seg=1111111, dp=1 in the same timestep; release -> next edge an=1110.
REQ-035 min_t=5, min_u=9, sec_t=3, sec_u=7 -> repeating an sequence 1110 x3, 1111, 1101 x3, 1111, 1011 x3, 1111, 0111 x3, 1111; seg 1111000, 0110000, 0010000, 0010010; dp=0 only during the an=1011 cycles.
REQ-036 Raise lap with sec_u=7, then set sec_u=8 -> sec_u slots stay 1111000; drop lap -> next sec_u slot shows 0000000.
REQ-037 sec_t=6 and sec_u=12 -> both slots show 0111111.
REQ-038 min_t=0 -> with LEADING_ZERO_BLANK_EN defined the min_t slot gives an=1111, seg=1111111; without it, an=0111, seg=1000000.
REQ-039 Simultaneous lap rise and sec_u change on the same edge -> hold captures the pre-edge sec_u value.
